lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_align_pkg.sv | 50 +++++
 rtl/lsu_lane.sv | 40 ++++
 rtl/lsu_align.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_align.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_align_pkg.sv
// Shared types and helpers for the load/store alignment unit: access sizes,
// byte strobes, FSM states, and the load lane-extract / extend functions.
package lsu_align_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  // Widest strobe the unit ever drives (DATA_W = 64 -> 8 byte lanes).
  typedef logic [7:0] strobe_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] msize_bytes(input msize_t m);
    case (m)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Pull the access bytes out of the holding register, starting at byte off.
  function automatic logic [63:0] lane_extract(input logic [127:0] hold,
                                               input logic [3:0]   off);
    return 64'(hold >> {off, 3'b000});
  endfunction

  // Zero- or sign-extend the low n bytes of raw to 64 bits.
  function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                              input msize_t      m,
                                              input logic        uns);
    case (m)
      MSIZE1:  return uns ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      MSIZE2:  return uns ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      MSIZE4:  return uns ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane generator for one bus beat: produces the byte strobe and the
// lane-positioned store data for either the first or the second beat.
module lsu_lane
  import lsu_align_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [3:0]          off_i,
  input  logic [3:0]          nbytes_i,
  input  logic                beat1_i,
  input  logic [63:0]         wdata_i,
  output logic [DATA_W/8-1:0] strobe_o,
  output logic [DATA_W-1:0]   data_o
);

  localparam int B = DATA_W / 8;

  logic [15:0] span_s;
  logic [4:0]  rem_s;
  logic [6:0]  lsh_s;
  logic [6:0]  rsh_s;
  strobe_t     lanes_s;

  // First beat covers bytes off..B-1; second beat picks up the spill into the next word.
  always_comb begin
    rem_s = {1'b0, off_i} + {1'b0, nbytes_i} - 5'(B);
    lsh_s = {off_i, 3'b000};
    rsh_s = {(4'(B) - off_i), 3'b000};
    if (!beat1_i) begin
      span_s = ((16'h1 << nbytes_i) - 16'h1) << off_i;
      data_o = DATA_W'({64'h0, wdata_i} << lsh_s);
    end else begin
      span_s = (16'h1 << rem_s) - 16'h1;
      data_o = DATA_W'(wdata_i >> rsh_s);
    end
    lanes_s  = strobe_t'(span_s);
    strobe_o = B'(lanes_s);
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: converts a core access of 1/2/4/8 bytes into one
// or two aligned bus beats, and assembles/extends the load result.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [63:0]         req_addr,
  input  msize_t              req_msize,
  input  logic                req_unsigned,
  input  logic [63:0]         req_wdata,
  output logic                resp_valid,
  output logic [63:0]         resp_rdata,
  output logic                resp_err,
  output logic                dreq_valid,
  output logic [63:0]         dreq_addr,
  output msize_t              dreq_size,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_data,
  input  logic                dresp_data_ok,
  input  logic [DATA_W-1:0]   dresp_data
);

  localparam int B    = DATA_W / 8;
  localparam int OFFW = $clog2(B);

  lsu_state_t          state_q;
  logic                ready_q;
  logic                write_q;
  logic [63:0]         addr_q;
  msize_t              msize_q;
  logic                uns_q;
  logic [63:0]         wdata_q;
  logic                cross_q;
  logic [2*DATA_W-1:0] hold_q;
  logic                resp_valid_q;
  logic [63:0]         resp_rdata_q;
  logic                resp_err_q;
  logic                dreq_valid_q;
  logic [63:0]         dreq_addr_q;
  msize_t              dreq_size_q;
  logic [B-1:0]        dreq_strobe_q;
  logic [DATA_W-1:0]   dreq_data_q;

  logic [3:0]          req_off_s;
  logic [3:0]          req_n_s;
  logic                req_cross_s;
  logic [3:0]          cap_off_s;
  logic [3:0]          cap_n_s;
  logic [63:0]         beat1_addr_s;
  logic [B-1:0]        l0_strobe_s;
  logic [DATA_W-1:0]   l0_data_s;
  logic [B-1:0]        l1_strobe_s;
  logic [DATA_W-1:0]   l1_data_s;
  logic [2*DATA_W-1:0] hold_d;
  logic [63:0]         rdata_d;

  assign req_off_s    = 4'(req_addr[OFFW-1:0]);
  assign req_n_s      = msize_bytes(req_msize);
  assign req_cross_s  = ({1'b0, req_off_s} + {1'b0, req_n_s}) > 5'(B);
  assign cap_off_s    = 4'(addr_q[OFFW-1:0]);
  assign cap_n_s      = msize_bytes(msize_q);
  assign beat1_addr_s = (addr_q & ~64'(B - 1)) + 64'(B);

  // First-beat lanes come straight from the request so they can be registered at capture.
  lsu_lane #(.DATA_W(DATA_W)) u_lane0 (
    .off_i    (req_off_s),
    .nbytes_i (req_n_s),
    .beat1_i  (1'b0),
    .wdata_i  (req_wdata),
    .strobe_o (l0_strobe_s),
    .data_o   (l0_data_s)
  );

  lsu_lane #(.DATA_W(DATA_W)) u_lane1 (
    .off_i    (cap_off_s),
    .nbytes_i (cap_n_s),
    .beat1_i  (1'b1),
    .wdata_i  (wdata_q),
    .strobe_o (l1_strobe_s),
    .data_o   (l1_data_s)
  );

  // Merge the beat currently completing into the holding register and extend the result.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_BEAT0) begin
      hold_d[DATA_W-1:0] = dresp_data;
    end else if (state_q == ST_BEAT1) begin
      hold_d[2*DATA_W-1:DATA_W] = dresp_data;
    end else begin
      hold_d = hold_q;
    end
    rdata_d = extend_load(lane_extract(128'(hold_d), cap_off_s), msize_q, uns_q);
  end

  // Transaction FSM with all handshake and bus outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      ready_q       <= 1'b1;
      write_q       <= 1'b0;
      addr_q        <= 64'h0;
      msize_q       <= MSIZE1;
      uns_q         <= 1'b0;
      wdata_q       <= 64'h0;
      cross_q       <= 1'b0;
      hold_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 64'h0;
      resp_err_q    <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= 64'h0;
      dreq_size_q   <= MSIZE1;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            write_q <= req_write;
            addr_q  <= req_addr;
            msize_q <= req_msize;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            cross_q <= req_cross_s;
            hold_q  <= '0;
            if (req_cross_s && (ALLOW_MISALIGN == 0)) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 64'h0;
            end else begin
              state_q       <= ST_BEAT0;
              dreq_valid_q  <= 1'b1;
              dreq_addr_q   <= req_addr;
              dreq_size_q   <= req_msize;
              dreq_strobe_q <= l0_strobe_s;
              dreq_data_q   <= req_write ? l0_data_s : '0;
            end
          end
        end
        ST_BEAT0: begin
          if (dresp_data_ok) begin
            hold_q <= hold_d;
            if (cross_q) begin
              state_q       <= ST_BEAT1;
              dreq_addr_q   <= beat1_addr_s;
              dreq_strobe_q <= l1_strobe_s;
              dreq_data_q   <= write_q ? l1_data_s : '0;
            end else begin
              state_q       <= ST_RESP;
              dreq_valid_q  <= 1'b0;
              dreq_addr_q   <= 64'h0;
              dreq_strobe_q <= '0;
              dreq_data_q   <= '0;
              resp_valid_q  <= 1'b1;
              resp_err_q    <= 1'b0;
              resp_rdata_q  <= write_q ? 64'h0 : rdata_d;
            end
          end
        end
        ST_BEAT1: begin
          if (dresp_data_ok) begin
            hold_q        <= hold_d;
            state_q       <= ST_RESP;
            dreq_valid_q  <= 1'b0;
            dreq_addr_q   <= 64'h0;
            dreq_strobe_q <= '0;
            dreq_data_q   <= '0;
            resp_valid_q  <= 1'b1;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= write_q ? 64'h0 : rdata_d;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 64'h0;
        end
        default: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          dreq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a 64-bit split-capable unit, a 32-bit
// split-capable unit and a 32-bit unit that rejects misaligned accesses.
module tb_lsu_align;
  import lsu_align_pkg::*;

  logic        clk;
  logic        resetn;
  logic        r_write;
  logic [63:0] r_addr;
  msize_t      r_msize;
  logic        r_uns;
  logic [63:0] r_wdata;

  logic        a_rv, a_rdy, a_vld, a_err, a_dv, a_ok;
  logic [63:0] a_rdata, a_daddr, a_ddata, a_dd;
  msize_t      a_dsize;
  logic [7:0]  a_dstrb;

  logic        b_rv, b_rdy, b_vld, b_err, b_dv, b_ok;
  logic [63:0] b_rdata, b_daddr;
  logic [31:0] b_ddata, b_dd;
  msize_t      b_dsize;
  logic [3:0]  b_dstrb;

  logic        c_rv, c_rdy, c_vld, c_err, c_dv, c_ok;
  logic [63:0] c_rdata, c_daddr;
  logic [31:0] c_ddata, c_dd;
  msize_t      c_dsize;
  logic [3:0]  c_dstrb;

  int errors = 0;
  int checks = 0;

  lsu_align #(.DATA_W(64), .ALLOW_MISALIGN(1)) u_a (
    .clk(clk), .resetn(resetn), .req_valid(a_rv), .req_ready(a_rdy),
    .req_write(r_write), .req_addr(r_addr), .req_msize(r_msize),
    .req_unsigned(r_uns), .req_wdata(r_wdata), .resp_valid(a_vld),
    .resp_rdata(a_rdata), .resp_err(a_err), .dreq_valid(a_dv),
    .dreq_addr(a_daddr), .dreq_size(a_dsize), .dreq_strobe(a_dstrb),
    .dreq_data(a_ddata), .dresp_data_ok(a_ok), .dresp_data(a_dd)
  );

  lsu_align #(.DATA_W(32), .ALLOW_MISALIGN(1)) u_b (
    .clk(clk), .resetn(resetn), .req_valid(b_rv), .req_ready(b_rdy),
    .req_write(r_write), .req_addr(r_addr), .req_msize(r_msize),
    .req_unsigned(r_uns), .req_wdata(r_wdata), .resp_valid(b_vld),
    .resp_rdata(b_rdata), .resp_err(b_err), .dreq_valid(b_dv),
    .dreq_addr(b_daddr), .dreq_size(b_dsize), .dreq_strobe(b_dstrb),
    .dreq_data(b_ddata), .dresp_data_ok(b_ok), .dresp_data(b_dd)
  );

  lsu_align #(.DATA_W(32), .ALLOW_MISALIGN(0)) u_c (
    .clk(clk), .resetn(resetn), .req_valid(c_rv), .req_ready(c_rdy),
    .req_write(r_write), .req_addr(r_addr), .req_msize(r_msize),
    .req_unsigned(r_uns), .req_wdata(r_wdata), .resp_valid(c_vld),
    .resp_rdata(c_rdata), .resp_err(c_err), .dreq_valid(c_dv),
    .dreq_addr(c_daddr), .dreq_size(c_dsize), .dreq_strobe(c_dstrb),
    .dreq_data(c_ddata), .dresp_data_ok(c_ok), .dresp_data(c_dd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request to one unit for one cycle; returns at the negedge after capture.
  task automatic issue(input int which, input logic wr, input logic [63:0] addr,
                       input msize_t sz, input logic uns, input logic [63:0] wd);
    r_write = wr; r_addr = addr; r_msize = sz; r_uns = uns; r_wdata = wd;
    if (which == 0) a_rv = 1'b1;
    else if (which == 1) b_rv = 1'b1;
    else c_rv = 1'b1;
    @(negedge clk);
    a_rv = 1'b0; b_rv = 1'b0; c_rv = 1'b0;
  endtask

  // Complete the current bus beat of one unit with the given data.
  task automatic beat(input int which, input logic [63:0] d);
    if (which == 0) begin a_ok = 1'b1; a_dd = d; end
    else if (which == 1) begin b_ok = 1'b1; b_dd = d[31:0]; end
    else begin c_ok = 1'b1; c_dd = d[31:0]; end
    @(negedge clk);
    a_ok = 1'b0; b_ok = 1'b0; c_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    r_write = 1'b0; r_addr = 64'h0; r_msize = MSIZE1; r_uns = 1'b0; r_wdata = 64'h0;
    a_rv = 1'b0; a_ok = 1'b0; a_dd = 64'h0;
    b_rv = 1'b0; b_ok = 1'b0; b_dd = 32'h0;
    c_rv = 1'b0; c_ok = 1'b0; c_dd = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    chk("rst_ready",  {63'h0, a_rdy}, 64'h1);
    chk("rst_rvalid", {63'h0, a_vld}, 64'h0);
    chk("rst_rdata",  a_rdata, 64'h0);
    chk("rst_err",    {63'h0, a_err}, 64'h0);
    chk("rst_dvalid", {63'h0, a_dv},  64'h0);
    chk("rst_daddr",  a_daddr, 64'h0);
    chk("rst_dstrb",  {56'h0, a_dstrb}, 64'h0);
    chk("rst_ddata",  a_ddata, 64'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Bus completion while idle is ignored
    a_ok = 1'b1; a_dd = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    a_ok = 1'b0;
    chk("idle_ok_ready", {63'h0, a_rdy}, 64'h1);
    chk("idle_ok_rvalid", {63'h0, a_vld}, 64'h0);
    chk("idle_ok_dvalid", {63'h0, a_dv}, 64'h0);

    // lb 0x1003, signed
    issue(0, 1'b0, 64'h1003, MSIZE1, 1'b0, 64'h0);
    chk("lb_dvalid", {63'h0, a_dv}, 64'h1);
    chk("lb_ready", {63'h0, a_rdy}, 64'h0);
    chk("lb_daddr", a_daddr, 64'h1003);
    chk("lb_dstrb", {56'h0, a_dstrb}, 64'h08);
    beat(0, 64'h0000_0000_8000_0000);
    chk("lb_rvalid", {63'h0, a_vld}, 64'h1);
    chk("lb_rdata", a_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_err", {63'h0, a_err}, 64'h0);
    @(negedge clk);
    chk("lb_rvalid_off", {63'h0, a_vld}, 64'h0);
    chk("lb_ready_back", {63'h0, a_rdy}, 64'h1);

    // lbu 0x1003
    issue(0, 1'b0, 64'h1003, MSIZE1, 1'b1, 64'h0);
    beat(0, 64'h0000_0000_8000_0000);
    chk("lbu_rdata", a_rdata, 64'h80);
    @(negedge clk);

    // sw 0x1006 crossing, bus held off for 5 cycles in the first beat
    issue(0, 1'b1, 64'h1006, MSIZE4, 1'b0, 64'h0000_0000_AABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      chk("sw_b0_dvalid", {63'h0, a_dv}, 64'h1);
      chk("sw_b0_daddr", a_daddr, 64'h1006);
      chk("sw_b0_dstrb", {56'h0, a_dstrb}, 64'hC0);
      chk("sw_b0_ddata", a_ddata, 64'hCCDD_0000_0000_0000);
      @(negedge clk);
    end
    chk("sw_b0_size", {62'h0, a_dsize}, {62'h0, MSIZE4});
    beat(0, 64'h0);
    chk("sw_b1_dvalid", {63'h0, a_dv}, 64'h1);
    chk("sw_b1_daddr", a_daddr, 64'h1008);
    chk("sw_b1_dstrb", {56'h0, a_dstrb}, 64'h03);
    chk("sw_b1_ddata", a_ddata, 64'h0000_0000_0000_AABB);
    chk("sw_b1_rvalid", {63'h0, a_vld}, 64'h0);
    beat(0, 64'h0);
    chk("sw_rvalid", {63'h0, a_vld}, 64'h1);
    chk("sw_rdata", a_rdata, 64'h0);
    chk("sw_dvalid", {63'h0, a_dv}, 64'h0);
    @(negedge clk);

    // ld 0x2000 on the 32-bit unit: always two beats
    issue(1, 1'b0, 64'h2000, MSIZE8, 1'b0, 64'h0);
    chk("ld32_b0_daddr", b_daddr, 64'h2000);
    chk("ld32_b0_dstrb", {60'h0, b_dstrb}, 64'hF);
    beat(1, 64'h1122_3344);
    chk("ld32_b1_dvalid", {63'h0, b_dv}, 64'h1);
    chk("ld32_b1_daddr", b_daddr, 64'h2004);
    chk("ld32_b1_dstrb", {60'h0, b_dstrb}, 64'hF);
    beat(1, 64'h5566_7788);
    chk("ld32_rvalid", {63'h0, b_vld}, 64'h1);
    chk("ld32_rdata", b_rdata, 64'h5566_7788_1122_3344);
    @(negedge clk);

    // lh 0x2003 on the 32-bit unit: one byte in each word
    issue(1, 1'b0, 64'h2003, MSIZE2, 1'b0, 64'h0);
    chk("lh32_b0_dstrb", {60'h0, b_dstrb}, 64'h8);
    beat(1, 64'hAB00_0000);
    chk("lh32_b1_daddr", b_daddr, 64'h2004);
    chk("lh32_b1_dstrb", {60'h0, b_dstrb}, 64'h1);
    beat(1, 64'h0000_00CD);
    chk("lh32_rdata", b_rdata, 64'hFFFF_FFFF_FFFF_CDAB);
    @(negedge clk);

    // Rejecting unit: word that exactly fills the bus is not a crossing
    issue(2, 1'b0, 64'h2004, MSIZE4, 1'b0, 64'h0);
    chk("lw_fit_dvalid", {63'h0, c_dv}, 64'h1);
    chk("lw_fit_dstrb", {60'h0, c_dstrb}, 64'hF);
    beat(2, 64'h8000_0001);
    chk("lw_fit_rdata", c_rdata, 64'hFFFF_FFFF_8000_0001);
    chk("lw_fit_err", {63'h0, c_err}, 64'h0);
    @(negedge clk);

    // Rejecting unit: lw 0x3002 crosses -> error response with no bus activity
    issue(2, 1'b0, 64'h3002, MSIZE4, 1'b0, 64'h0);
    chk("rej_rvalid", {63'h0, c_vld}, 64'h1);
    chk("rej_err", {63'h0, c_err}, 64'h1);
    chk("rej_dvalid", {63'h0, c_dv}, 64'h0);
    @(negedge clk);
    chk("rej_rvalid_off", {63'h0, c_vld}, 64'h0);
    chk("rej_ready", {63'h0, c_rdy}, 64'h1);
    chk("rej_dvalid2", {63'h0, c_dv}, 64'h0);

    // sd 0x1004 split, aborted by reset during the second beat
    issue(0, 1'b1, 64'h1004, MSIZE8, 1'b0, 64'h1122_3344_5566_7788);
    chk("sd_b0_dstrb", {56'h0, a_dstrb}, 64'hF0);
    chk("sd_b0_ddata", a_ddata, 64'h5566_7788_0000_0000);
    beat(0, 64'h0);
    chk("sd_b1_dvalid", {63'h0, a_dv}, 64'h1);
    chk("sd_b1_dstrb", {56'h0, a_dstrb}, 64'h0F);
    chk("sd_b1_ddata", a_ddata, 64'h0000_0000_1122_3344);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_dvalid", {63'h0, a_dv}, 64'h0);
    chk("abort_ready", {63'h0, a_rdy}, 64'h1);
    chk("abort_daddr", a_daddr, 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_rvalid", {63'h0, a_vld}, 64'h0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rvalid", {63'h0, a_vld}, 64'h0);
    chk("post_ready", {63'h0, a_rdy}, 64'h1);
    chk("post_dvalid", {63'h0, a_dv}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
